oldland_memarb: RTL and testbench

OLDLAND_MEMARB -- requirements
Module: oldland_memarb

---
 rtl/oldland_memarb.sv | 167 ++++++++++++++++
 tb/tb_oldland_memarb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oldland_memarb.sv
// Two-master (fetch/data) round-robin arbiter onto a single memory bus.
// Define OLDLAND_MEMARB_TIMEOUT_EN to abort transactions that never see m_ack.
module oldland_memarb #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_access,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    input  logic        d_access,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [1:0]  d_width,
    input  logic [31:0] d_wr_val,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    output logic        m_access,
    output logic [31:0] m_addr,
    output logic        m_wr_en,
    output logic [1:0]  m_width,
    output logic [31:0] m_wr_val,
    input  logic [31:0] m_data,
    input  logic        m_ack
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;
    logic        m_access_q, m_access_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic        m_wr_en_q, m_wr_en_d;
    logic [1:0]  m_width_q, m_width_d;
    logic [31:0] m_wr_val_q, m_wr_val_d;
    logic        busy_c, timeout_c, grant_fetch_c, grant_data_c;

    assign busy_c        = (state_q != ST_IDLE);
    assign grant_fetch_c = (state_q == ST_IDLE) && (state_d == ST_FETCH);
    assign grant_data_c  = (state_q == ST_IDLE) && (state_d == ST_DATA);

`ifdef OLDLAND_MEMARB_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (grant_fetch_c || grant_data_c)
            tmo_cnt_d = '0;
        else if (busy_c && !m_ack)
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end

    // A coincident m_ack wins: the transaction completes normally.
    assign timeout_c = busy_c && !m_ack && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // TIMEOUT_CYCLES is at least 2, so this is constant 0: no aborts in this build.
    assign timeout_c = (TIMEOUT_CYCLES == 0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: round-robin on contention, no regrant in the completion cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_access && d_access)
                    state_d = last_data_q ? ST_FETCH : ST_DATA;
                else if (i_access)
                    state_d = ST_FETCH;
                else if (d_access)
                    state_d = ST_DATA;
            end
            ST_FETCH, ST_DATA: begin
                if (m_ack || timeout_c)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: owner sees m_ack/m_data for one cycle, data zero otherwise
    always_comb begin
        i_ack   = 1'b0;
        i_data  = 32'h0;
        d_ack   = 1'b0;
        d_data  = 32'h0;
        d_error = 1'b0;
        if (state_q == ST_FETCH) begin
            i_ack  = m_ack || timeout_c;
            i_data = m_ack ? m_data : 32'h0;
        end else if (state_q == ST_DATA) begin
            d_ack   = m_ack || timeout_c;
            d_data  = m_ack ? m_data : 32'h0;
            d_error = timeout_c;
        end
    end

    // Bus request registers: captured on the grant edge only
    always_comb begin
        last_data_d = last_data_q;
        m_access_d  = m_access_q;
        m_addr_d    = m_addr_q;
        m_wr_en_d   = m_wr_en_q;
        m_width_d   = m_width_q;
        m_wr_val_d  = m_wr_val_q;
        if (grant_fetch_c) begin
            last_data_d = 1'b0;
            m_access_d  = 1'b1;
            m_addr_d    = i_addr;
            m_wr_en_d   = 1'b0;
            m_width_d   = 2'b10;
            m_wr_val_d  = 32'h0;
        end else if (grant_data_c) begin
            last_data_d = 1'b1;
            m_access_d  = 1'b1;
            m_addr_d    = d_addr;
            m_wr_en_d   = d_wr_en;
            m_width_d   = d_width;
            m_wr_val_d  = d_wr_val;
        end else if (busy_c && (m_ack || timeout_c)) begin
            m_access_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data_q <= 1'b0;
            m_access_q  <= 1'b0;
            m_addr_q    <= 32'h0;
            m_wr_en_q   <= 1'b0;
            m_width_q   <= 2'b00;
            m_wr_val_q  <= 32'h0;
        end else begin
            last_data_q <= last_data_d;
            m_access_q  <= m_access_d;
            m_addr_q    <= m_addr_d;
            m_wr_en_q   <= m_wr_en_d;
            m_width_q   <= m_width_d;
            m_wr_val_q  <= m_wr_val_d;
        end
    end

    assign m_access = m_access_q;
    assign m_addr   = m_addr_q;
    assign m_wr_en  = m_wr_en_q;
    assign m_width  = m_width_q;
    assign m_wr_val = m_wr_val_q;

endmodule

// File: tb/tb_oldland_memarb.sv
// Scoreboard bench for oldland_memarb: expected bus transactions are queued as
// requests are driven and checked when the grant and ack appear on the bus.
module tb_oldland_memarb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_access = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_data;
    logic        i_ack;
    logic        d_access = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic        d_wr_en = 1'b0;
    logic [1:0]  d_width = 2'b00;
    logic [31:0] d_wr_val = 32'h0;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;
    logic        m_access;
    logic [31:0] m_addr;
    logic        m_wr_en;
    logic [1:0]  m_width;
    logic [31:0] m_wr_val;
    logic [31:0] m_data = 32'h0;
    logic        m_ack = 1'b0;

    oldland_memarb #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack),
        .d_access(d_access), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_width(d_width),
        .d_wr_val(d_wr_val), .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
        .m_access(m_access), .m_addr(m_addr), .m_wr_en(m_wr_en), .m_width(m_width),
        .m_wr_val(m_wr_val), .m_data(m_data), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          owner_d;
        logic [31:0] addr;
        logic        wr_en;
        logic [1:0]  width;
        logic [31:0] wr_val;
        logic [31:0] rdata;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t cur;
    int total = 0;
    int bad   = 0;
    bit ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input bit owner_d, input logic [31:0] addr, input logic wr_en,
                        input logic [1:0] width, input logic [31:0] wr_val,
                        input logic [31:0] rdata);
        sb_item_t e;
        e.owner_d = owner_d;
        e.addr    = addr;
        e.wr_en   = wr_en;
        e.width   = width;
        e.wr_val  = wr_val;
        e.rdata   = rdata;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        m_ack  = 1'b0;
        m_data = 32'h0;
    endtask

    // Wait (bounded) for m_access, then compare bus attributes with the next queued item.
    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            #1;
            if (m_access) got = 1'b1;
        end
        check("grant_seen", 32'(got), 32'd1);
        if (got) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
                got = 1'b0;
            end else begin
                cur = sb_q.pop_front();
                check("m_addr",   m_addr,         cur.addr);
                check("m_wr_en",  32'(m_wr_en),   32'(cur.wr_en));
                check("m_width",  32'(m_width),   32'(cur.width));
                check("m_wr_val", m_wr_val,       cur.wr_val);
            end
        end
    endtask

    // Ack arrives in granted cycle `lat` (1 = earliest); checks acks in every granted cycle.
    task automatic complete(input int lat);
        bit ack_now;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) tick();
            ack_now = (c == lat);
            if (ack_now) begin
                m_ack  = 1'b1;
                m_data = cur.rdata;
            end
            #1;
            check("m_access_held", 32'(m_access), 32'd1);
            check("i_ack",   32'(i_ack),   32'(ack_now && !cur.owner_d));
            check("d_ack",   32'(d_ack),   32'(ack_now &&  cur.owner_d));
            check("i_data",  i_data, (ack_now && !cur.owner_d) ? cur.rdata : 32'h0);
            check("d_data",  d_data, (ack_now &&  cur.owner_d) ? cur.rdata : 32'h0);
            check("d_error", 32'(d_error), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_access", 32'(m_access), 32'd0);
        check("rst_m_addr",   m_addr,        32'h0);
        check("rst_m_wr_en",  32'(m_wr_en),  32'd0);
        check("rst_m_width",  32'(m_width),  32'd0);
        check("rst_m_wr_val", m_wr_val,      32'h0);
        check("rst_acks",     32'({i_ack, d_ack, d_error}), 32'd0);
        tick();
        rst = 1'b0;

        // Contention from reset: DATA first, then FETCH, then DATA again
        i_access = 1'b1; i_addr = 32'h0000_0A00;
        d_access = 1'b1; d_addr = 32'h0000_0B00; d_wr_en = 1'b0; d_width = 2'b10; d_wr_val = 32'h0;
        push(1'b1, 32'h0000_0B00, 1'b0, 2'b10, 32'h0, 32'h1111_2222);
        push(1'b0, 32'h0000_0A00, 1'b0, 2'b10, 32'h0, 32'h3333_4444);
        wait_grant(ok);
        if (ok) complete(1);
        tick();
        d_addr = 32'h0000_0C00;
        push(1'b1, 32'h0000_0C00, 1'b0, 2'b10, 32'h0, 32'h5555_6666);
        #1;
        check("gap_after_data", 32'(m_access), 32'd0);
        wait_grant(ok);
        if (ok) complete(2);
        tick();
        i_access = 1'b0;
        #1;
        check("gap_after_fetch", 32'(m_access), 32'd0);
        wait_grant(ok);
        if (ok) complete(1);
        tick();
        d_access = 1'b0;
        #1;
        check("idle_after_rr", 32'(m_access), 32'd0);

        // Stray m_ack while idle
        tick();
        m_ack = 1'b1; m_data = 32'h1234_5678;
        #1;
        check("idle_ack_acks", 32'({i_ack, d_ack, d_error}), 32'd0);
        check("idle_ack_idata", i_data, 32'h0);
        check("idle_ack_ddata", d_data, 32'h0);
        tick();
        #1;
        check("idle_ack_no_grant", 32'(m_access), 32'd0);

        // Fetch with the ack in the second granted cycle
        tick();
        i_access = 1'b1; i_addr = 32'h0000_0100;
        push(1'b0, 32'h0000_0100, 1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF);
        wait_grant(ok);
        if (ok) complete(2);
        tick();
        i_access = 1'b0;
        #1;
        check("fetch_access_clr", 32'(m_access), 32'd0);

        // Data store
        tick();
        d_access = 1'b1; d_addr = 32'h0000_2000; d_wr_en = 1'b1; d_width = 2'b01; d_wr_val = 32'h0000_55AA;
        push(1'b1, 32'h0000_2000, 1'b1, 2'b01, 32'h0000_55AA, 32'h0BAD_F00D);
        wait_grant(ok);
        if (ok) complete(1);
        tick();
        d_access = 1'b0; d_wr_en = 1'b0;
        #1;
        check("store_access_clr", 32'(m_access), 32'd0);

        // Reset while FETCH is granted, then a late m_ack
        tick();
        i_access = 1'b1; i_addr = 32'h0000_0400;
        push(1'b0, 32'h0000_0400, 1'b0, 2'b10, 32'h0, 32'h0);
        wait_grant(ok);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_access", 32'(m_access), 32'd0);
        check("midrst_addr",   m_addr,        32'h0);
        m_ack = 1'b1; m_data = 32'hFEED_FACE;
        #1;
        check("midrst_i_ack",  32'(i_ack),  32'd0);
        check("midrst_i_data", i_data,      32'h0);
        tick();
        i_access = 1'b0;
        rst = 1'b0;
        m_ack = 1'b1; m_data = 32'hFEED_FACE;
        #1;
        check("postrst_i_ack", 32'(i_ack),   32'd0);
        tick();
        #1;
        check("postrst_idle", 32'(m_access), 32'd0);

`ifdef OLDLAND_MEMARB_TIMEOUT_EN
        // Load that never gets m_ack: aborted on the 4th granted cycle
        tick();
        d_access = 1'b1; d_addr = 32'h0000_3000; d_wr_en = 1'b0; d_width = 2'b10; d_wr_val = 32'h0;
        push(1'b1, 32'h0000_3000, 1'b0, 2'b10, 32'h0, 32'h0);
        wait_grant(ok);
        if (ok) begin
            for (int c = 1; c <= 4; c++) begin
                if (c > 1) tick();
                m_data = 32'hFFFF_FFFF;
                #1;
                check("tmo_d_ack",   32'(d_ack),   32'(c == 4));
                check("tmo_d_error", 32'(d_error), 32'(c == 4));
                check("tmo_d_data",  d_data,       32'h0);
                check("tmo_i_ack",   32'(i_ack),   32'd0);
            end
        end
        tick();
        d_access = 1'b0;
        #1;
        check("tmo_idle", 32'(m_access), 32'd0);

        // m_ack coinciding with the timeout is a normal completion
        tick();
        d_access = 1'b1; d_addr = 32'h0000_3004;
        push(1'b1, 32'h0000_3004, 1'b0, 2'b10, 32'h0, 32'h7777_8888);
        wait_grant(ok);
        if (ok) complete(4);
        tick();
        d_access = 1'b0;
        #1;
        check("tmo_tie_idle", 32'(m_access), 32'd0);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
